dk_input_ctrl: RTL and testbench
================================

Name: dk_input_ctrl

Overview:
- Input-conditioning stage between hps_io (PS/2 key events, joysticks, status bits) and dkong_top's active-low player/coin/start inputs.
- Latches keyboard make/break events and merges them with joystick bits.
- Applies the screen-rotation remap.
- Replaces the old combinational "coin = start1|start2" with a timed coin -> gap -> start sequencer, so one press inserts a credit and then starts the game.

Parameters:
- TICK_DIV, 24576, clk cycles per 1 ms tick (24.576 MHz).
- COIN_MS, 100, coin pulse width in ticks.
- GAP_MS, 200, delay between coin release and start assertion, in ticks.
- START_MS, 100, start pulse width in ticks.
- AF_MS, 50, autofire half-period in ticks (only with the optional feature).

Ports:
- I_CLK_24576M  in  1  system clock.
- I_RESETn  in  1  asynchronous active-low reset.
- I_PS2_KEY  in  11  [10] toggle on each event, [9] pressed, [8:0] scancode (bit 8 = E0 extended).
- I_JOY  in  16  OR of both joysticks; [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin; active-high.
- I_NO_ROTATE  in  1  1 = horizontal orientation remap.
- O_U  out  1  up, active-low.
- O_D  out  1  down, active-low.
- O_L  out  1  left, active-low.
- O_R  out  1  right, active-low.
- O_J  out  1  jump, active-low.
- O_S1  out  1  start 1P, active-low.
- O_S2  out  1  start 2P, active-low.
- O_C1  out  1  coin, active-low.
- O_BUSY  out  1  coin sequencer not IDLE.

Behaviour:
- Reset: clock and reset are I_CLK_24576M and I_RESETn; reset is asynchronous and active-low. All active-low outputs reset to 1, O_BUSY to 0, key latches to 0, FSM to IDLE, tick prescaler and ms counter to 0.
- Key decode:
  - Register I_PS2_KEY[10] each cycle; an event is a difference between the registered and current value.
  - On an event, the latch for the scancode takes the value of [9]. Codes matched with bit 8 ignored: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - Exact codes: 0x029 and 0x014 fire (shared latch; last event wins), 0x005 F1, 0x006 F2, 0x004 F3 coin.
  - Unknown codes are ignored.
- Merge: each m_x = key latch OR joystick bit.
- Rotation, when I_NO_ROTATE=1: U<-L, D<-R, L<-D, R<-U, applied to the merged signals. When 0, straight mapping.
- Direction and jump outputs are registered inversions of the merged values.
  - Latency from a joystick change: 1 clk.
  - Latency from a PS/2 event: 2 clk.
- Tick: prescaler counts 0..TICK_DIV-1 and produces a 1-cycle tick at the wrap. It runs freely; it is not restarted by FSM transitions, so every timed state lasts N ticks with -1 tick jitter.
- Coin FSM, with a 16-bit ms counter cleared on every state entry:
  - IDLE: O_C1, O_S1, O_S2 = 1. A rising edge of start1 or start2 (merged) latches which one into sel (start1 wins if both rise in the same cycle) -> COIN.
  - IDLE, coin key: a rising edge of the F3/joy[7] coin key -> COIN with sel = none.
  - COIN: O_C1 = 0. After COIN_MS ticks -> GAP.
  - GAP: all three outputs = 1. After GAP_MS ticks -> START if sel != none, else -> WAIT.
  - START: the selected O_Sx = 0. After START_MS ticks -> WAIT.
  - WAIT: go to IDLE once all start and coin sources are released.
  - New presses while not IDLE are ignored; there is no queuing.
  - O_BUSY = (state != IDLE), registered.
- Holding a start button produces exactly one sequence. A release followed by a re-press after WAIT starts a new one.
- A reset mid-sequence immediately returns all outputs to inactive and the FSM to IDLE.

Optional Feature:
- Macro DK_AUTOFIRE_EN.
- With it defined: while fire is held, O_J toggles every AF_MS ticks, starting at 0 (pressed) on the first cycle of the hold. A half-period counter is cleared on release, and O_J returns to 1 within 1 clk of release.
- Without it: O_J = ~fire registered, and no autofire counter is instantiated.

Decomposition:
- Package dk_input_pkg holds:
  - FSM state enum (IDLE, COIN, GAP, START, WAIT).
  - Scancode constants (SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_SPACE, SC_CTRL, SC_F1, SC_F2, SC_F3).
  - Joystick bit index constants.
- One sub-module, dk_ps2_latch: event detect plus key latches, outputting the 8 key-held bits.

Test Plan (TICK_DIV=4, COIN_MS=3, GAP_MS=2, START_MS=3, AF_MS=2 for sim):
- Reset held low with I_JOY=16'hFFFF -> all O_* = 1, O_BUSY = 0. Release reset -> O_U = 0 one clk after the first active edge.
- Pulse I_PS2_KEY to {toggle, 1, 9'h175} -> O_U = 0 2 clk later. Same code with pressed = 0 -> O_U = 1. Code 9'h075 behaves identically.
- I_NO_ROTATE=1, I_JOY[1]=1 -> O_U = 0, O_L = 1. I_JOY[3]=1 -> O_R = 0.
- Hold I_JOY[6] (start2) -> sequence:
  - O_C1 low for 12±4 clk.
  - All outputs high for 8±4 clk.
  - O_S2 low for 12±4 clk, O_S1 stays 1.
  - Stays in WAIT with O_BUSY = 1 until I_JOY[6] = 0, then IDLE.
- Coin key F3 event -> O_C1 pulse only, with no O_Sx pulse. Start1 asserted during COIN is ignored (still exactly one coin pulse, no start).
- Assert I_RESETn=0 during START -> O_S1 = 1 and O_BUSY = 0 asynchronously. With DK_AUTOFIRE_EN, holding space for 40 clk shows O_J toggling every 8±4 clk; release -> O_J = 1 the next clk.

Source files
------------

// File: rtl/dk_input_pkg.sv
// dk_input_pkg -- shared types and constants for the Donkey Kong input
// conditioning stage (dk_input_ctrl and dk_ps2_latch).
//   coin_state_t : coin -> gap -> start sequencer states
//   start_sel_t  : which start output the sequencer drives (or none)
//   SC_*         : PS/2 scancodes, bit 8 = E0 extended prefix
//   JOY_*        : bit positions in the merged joystick word
//   KEY_*        : bit positions in the key-held vector from dk_ps2_latch
package dk_input_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COIN  = 3'd1,
    GAP   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } coin_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_S1   = 2'd1,
    SEL_S2   = 2'd2
  } start_sel_t;

  // Arrow keys are matched on the low byte only (keypad and E0 arrows alias).
  localparam logic [8:0] SC_UP    = 9'h075;
  localparam logic [8:0] SC_DOWN  = 9'h072;
  localparam logic [8:0] SC_LEFT  = 9'h06B;
  localparam logic [8:0] SC_RIGHT = 9'h074;
  // Remaining keys are matched on all nine bits.
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_CTRL  = 9'h014;
  localparam logic [8:0] SC_F1    = 9'h005;
  localparam logic [8:0] SC_F2    = 9'h006;
  localparam logic [8:0] SC_F3    = 9'h004;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  localparam int KEY_UP     = 0;
  localparam int KEY_DOWN   = 1;
  localparam int KEY_LEFT   = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_FIRE   = 4;
  localparam int KEY_START1 = 5;
  localparam int KEY_START2 = 6;
  localparam int KEY_COIN   = 7;
  localparam int NUM_KEYS   = 8;

endpackage

// File: rtl/dk_ps2_latch.sv
// dk_ps2_latch -- turns hps_io PS/2 key events into held-key levels.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   ps2_key  : [10] toggles per event, [9] pressed, [8:0] scancode
//   key_held : one bit per recognised key (KEY_* order), 1 = held
// An event is seen in the cycle the toggle bit differs from its registered
// copy; the matching latch takes the pressed bit at the following edge.
module dk_ps2_latch
  import dk_input_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [10:0]         ps2_key,
  output logic [NUM_KEYS-1:0] key_held
);

  logic       toggle_q;
  logic       key_event;
  logic       pressed;
  logic [8:0] code;

  assign key_event = ps2_key[10] ^ toggle_q;
  assign pressed   = ps2_key[9];
  assign code      = ps2_key[8:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
      key_held <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      if (key_event) begin
        if (code[7:0] == SC_UP[7:0])         key_held[KEY_UP]    <= pressed;
        else if (code[7:0] == SC_DOWN[7:0])  key_held[KEY_DOWN]  <= pressed;
        else if (code[7:0] == SC_LEFT[7:0])  key_held[KEY_LEFT]  <= pressed;
        else if (code[7:0] == SC_RIGHT[7:0]) key_held[KEY_RIGHT] <= pressed;
        else begin
          case (code)
            // Space and Ctrl share one latch; whichever event came last wins.
            SC_SPACE, SC_CTRL: key_held[KEY_FIRE]   <= pressed;
            SC_F1:             key_held[KEY_START1] <= pressed;
            SC_F2:             key_held[KEY_START2] <= pressed;
            SC_F3:             key_held[KEY_COIN]   <= pressed;
            default:           ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/dk_input_ctrl.sv
// dk_input_ctrl -- input conditioning between hps_io and dkong_top.
//   I_CLK_24576M : system clock
//   I_RESETn     : asynchronous active-low reset
//   I_PS2_KEY    : PS/2 key event word from hps_io
//   I_JOY        : OR of both joysticks, active-high
//   I_NO_ROTATE  : 1 = horizontal orientation remap of the directions
//   O_U/O_D/O_L/O_R/O_J : registered active-low directions and jump
//   O_S1/O_S2/O_C1      : active-low start 1P / start 2P / coin
//   O_BUSY       : coin sequencer not idle
//   O_DBG_STATE  : current coin sequencer state (coin_state_t encoding)
// A start press becomes coin pulse -> gap -> start pulse so one press both
// inserts a credit and starts the game. Timing uses a free-running 1 ms
// tick, so each timed state lasts N ticks minus up to one tick of jitter.
// Optional build macro DK_AUTOFIRE_EN: jump toggles every AF_MS ticks
// while fire is held.
module dk_input_ctrl
  import dk_input_pkg::*;
#(
  parameter int TICK_DIV = 24576,
  parameter int COIN_MS  = 100,
  parameter int GAP_MS   = 200,
  parameter int START_MS = 100,
  parameter int AF_MS    = 50
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic [10:0] I_PS2_KEY,
  input  logic [15:0] I_JOY,
  input  logic        I_NO_ROTATE,
  output logic        O_U,
  output logic        O_D,
  output logic        O_L,
  output logic        O_R,
  output logic        O_J,
  output logic        O_S1,
  output logic        O_S2,
  output logic        O_C1,
  output logic        O_BUSY,
  output logic [2:0]  O_DBG_STATE
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] COIN_LAST  = 16'(COIN_MS - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_MS - 1);
  localparam logic [15:0] START_LAST = 16'(START_MS - 1);

  logic [NUM_KEYS-1:0] key_held;
  logic m_u, m_d, m_l, m_r, m_j, m_s1, m_s2, m_coin;
  logic r_u, r_d, r_l, r_r;
  logic unused_joy;

  dk_ps2_latch u_ps2_latch (
    .clk      (I_CLK_24576M),
    .rst_n    (I_RESETn),
    .ps2_key  (I_PS2_KEY),
    .key_held (key_held)
  );

  assign m_u    = key_held[KEY_UP]     | I_JOY[JOY_U];
  assign m_d    = key_held[KEY_DOWN]   | I_JOY[JOY_D];
  assign m_l    = key_held[KEY_LEFT]   | I_JOY[JOY_L];
  assign m_r    = key_held[KEY_RIGHT]  | I_JOY[JOY_R];
  assign m_j    = key_held[KEY_FIRE]   | I_JOY[JOY_FIRE];
  assign m_s1   = key_held[KEY_START1] | I_JOY[JOY_START1];
  assign m_s2   = key_held[KEY_START2] | I_JOY[JOY_START2];
  assign m_coin = key_held[KEY_COIN]   | I_JOY[JOY_COIN];

  assign unused_joy = ^I_JOY[15:8];

  // Horizontal play: the cabinet's up comes from the player's left, etc.
  always_comb begin
    r_u = m_u;
    r_d = m_d;
    r_l = m_l;
    r_r = m_r;
    if (I_NO_ROTATE) begin
      r_u = m_l;
      r_d = m_r;
      r_l = m_d;
      r_r = m_u;
    end
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      O_U <= 1'b1;
      O_D <= 1'b1;
      O_L <= 1'b1;
      O_R <= 1'b1;
    end else begin
      O_U <= ~r_u;
      O_D <= ~r_d;
      O_L <= ~r_l;
      O_R <= ~r_r;
    end
  end

  // Free-running 1 ms tick; never restarted by the sequencer.
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) tick_cnt <= '0;
    else           tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Coin sequencer.
  coin_state_t state_q, state_d;
  start_sel_t  sel_q, sel_d;
  logic [15:0] ms_cnt;
  logic        s1_q, s2_q, coin_q;
  logic        s1_rise, s2_rise, coin_rise;

  assign s1_rise   = m_s1 & ~s1_q;
  assign s2_rise   = m_s2 & ~s2_q;
  assign coin_rise = m_coin & ~coin_q;
  assign O_DBG_STATE = state_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (s1_rise) begin
          state_d = COIN;
          sel_d   = SEL_S1;
        end else if (s2_rise) begin
          state_d = COIN;
          sel_d   = SEL_S2;
        end else if (coin_rise) begin
          state_d = COIN;
          sel_d   = SEL_NONE;
        end
      end
      COIN:  if (tick && ms_cnt == COIN_LAST) state_d = GAP;
      GAP:   if (tick && ms_cnt == GAP_LAST)
               state_d = (sel_q != SEL_NONE) ? START : WAIT;
      START: if (tick && ms_cnt == START_LAST) state_d = WAIT;
      // Only rearm once every source is released, so a held button
      // yields exactly one sequence.
      WAIT:  if (!m_s1 && !m_s2 && !m_coin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      ms_cnt  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      coin_q  <= 1'b0;
      O_C1    <= 1'b1;
      O_S1    <= 1'b1;
      O_S2    <= 1'b1;
      O_BUSY  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      s1_q    <= m_s1;
      s2_q    <= m_s2;
      coin_q  <= m_coin;
      if (state_d != state_q) ms_cnt <= '0;
      else if (tick)          ms_cnt <= ms_cnt + 16'd1;
      O_C1   <= ~(state_d == COIN);
      O_S1   <= ~(state_d == START && sel_d == SEL_S1);
      O_S2   <= ~(state_d == START && sel_d == SEL_S2);
      O_BUSY <= (state_d != IDLE);
    end
  end

`ifdef DK_AUTOFIRE_EN
  localparam logic [15:0] AF_LAST = 16'(AF_MS - 1);
  logic        fire_q;
  logic        af_off;
  logic [15:0] af_cnt;

  // First held cycle shows "pressed"; then the phase flips every AF_MS ticks.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      fire_q <= 1'b0;
      af_off <= 1'b0;
      af_cnt <= '0;
      O_J    <= 1'b1;
    end else begin
      fire_q <= m_j;
      if (!m_j) begin
        af_off <= 1'b0;
        af_cnt <= '0;
        O_J    <= 1'b1;
      end else if (!fire_q) begin
        af_off <= 1'b0;
        af_cnt <= '0;
        O_J    <= 1'b0;
      end else if (tick) begin
        if (af_cnt == AF_LAST) begin
          af_cnt <= '0;
          af_off <= ~af_off;
          O_J    <= ~af_off;
        end else begin
          af_cnt <= af_cnt + 16'd1;
          O_J    <= af_off;
        end
      end
    end
  end
`else
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) O_J <= 1'b1;
    else           O_J <= ~m_j;
  end
`endif

endmodule

// File: tb/tb_dk_input_ctrl.sv
// tb_dk_input_ctrl -- bench for dk_input_ctrl with short sim timing.
module tb_dk_input_ctrl;

  localparam int TICK_DIV = 4;
  localparam int COIN_MS  = 3;
  localparam int GAP_MS   = 2;
  localparam int START_MS = 3;
  localparam int AF_MS    = 2;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [10:0] ps2;
  logic [15:0] joy;
  logic        rot;
  logic        o_u, o_d, o_l, o_r, o_j, o_s1, o_s2, o_c1, o_busy;
  logic [2:0]  o_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dk_input_ctrl #(
    .TICK_DIV (TICK_DIV),
    .COIN_MS  (COIN_MS),
    .GAP_MS   (GAP_MS),
    .START_MS (START_MS),
    .AF_MS    (AF_MS)
  ) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .I_PS2_KEY    (ps2),
    .I_JOY        (joy),
    .I_NO_ROTATE  (rot),
    .O_U          (o_u),
    .O_D          (o_d),
    .O_L          (o_l),
    .O_R          (o_r),
    .O_J          (o_j),
    .O_S1         (o_s1),
    .O_S2         (o_s2),
    .O_C1         (o_c1),
    .O_BUSY       (o_busy),
    .O_DBG_STATE  (o_state)
  );

  logic [4:0] dir_out;
  assign dir_out = {o_u, o_d, o_l, o_r, o_j};

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    ps2 = {~ps2[10], pressed, code};
  endtask

  // Follows one coin sequence; sel: 0 none, 1 start1, 2 start2.
  task automatic run_seq(input int sel, input bit inject_s1, input string tag);
    int n;
    int bad;
    int lows;
    n = 0;
    bad = 0;
    while (o_c1 !== 1'b0 && n < 40) begin step(); n++; end
    check({tag, " coin_seen"}, o_c1, 0);
    if (inject_s1) joy[5] = 1'b1;
    n = 0;
    while (o_c1 === 1'b0 && n < 40) begin
      if (o_s1 !== 1'b1 || o_s2 !== 1'b1) bad++;
      step(); n++;
    end
    check_range({tag, " coin_len"}, n, 9, 12);
    if (sel != 0) begin
      n = 0;
      while (o_c1 === 1'b1 && o_s1 === 1'b1 && o_s2 === 1'b1 && n < 40) begin step(); n++; end
      check_range({tag, " gap_len"}, n, 5, 8);
      n = 0;
      while (((sel == 1) ? o_s1 : o_s2) === 1'b0 && n < 40) begin
        if (((sel == 1) ? o_s2 : o_s1) !== 1'b1 || o_c1 !== 1'b1) bad++;
        step(); n++;
      end
      check_range({tag, " start_len"}, n, 9, 12);
    end else begin
      lows = 0;
      repeat (30) begin
        if (o_s1 !== 1'b1 || o_s2 !== 1'b1 || o_c1 !== 1'b1) lows++;
        step();
      end
      check({tag, " no_start_no_recoin"}, lows, 0);
    end
    check({tag, " other_outputs_idle"}, bad, 0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [15:0] joy;
    logic        rot;
    logic [4:0]  exp;   // {U,D,L,R,J} active-low
  } dir_vec_t;

  typedef struct {
    logic       pressed;
    logic [8:0] code;
    logic [4:0] exp;
  } key_vec_t;

  dir_vec_t dir_tbl[11];
  key_vec_t key_tbl[14];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] prev;
    logic [4:0] exp;
    int n;

    dir_tbl[0]  = '{16'h0000, 1'b0, 5'b11111};
    dir_tbl[1]  = '{16'h0001, 1'b0, 5'b11101};
    dir_tbl[2]  = '{16'h0002, 1'b0, 5'b11011};
    dir_tbl[3]  = '{16'h0004, 1'b0, 5'b10111};
    dir_tbl[4]  = '{16'h0008, 1'b0, 5'b01111};
    dir_tbl[5]  = '{16'h0010, 1'b0, 5'b11110};
    dir_tbl[6]  = '{16'h0002, 1'b1, 5'b01111};
    dir_tbl[7]  = '{16'h0001, 1'b1, 5'b10111};
    dir_tbl[8]  = '{16'h0004, 1'b1, 5'b11011};
    dir_tbl[9]  = '{16'h0008, 1'b1, 5'b11101};
    dir_tbl[10] = '{16'h000A, 1'b1, 5'b01101};

    key_tbl[0]  = '{1'b1, 9'h175, 5'b01111};
    key_tbl[1]  = '{1'b0, 9'h175, 5'b11111};
    key_tbl[2]  = '{1'b1, 9'h075, 5'b01111};
    key_tbl[3]  = '{1'b0, 9'h075, 5'b11111};
    key_tbl[4]  = '{1'b1, 9'h072, 5'b10111};
    key_tbl[5]  = '{1'b1, 9'h16B, 5'b10011};
    key_tbl[6]  = '{1'b0, 9'h072, 5'b11011};
    key_tbl[7]  = '{1'b0, 9'h16B, 5'b11111};
    key_tbl[8]  = '{1'b1, 9'h074, 5'b11101};
    key_tbl[9]  = '{1'b0, 9'h074, 5'b11111};
    key_tbl[10] = '{1'b1, 9'h014, 5'b11110};
    key_tbl[11] = '{1'b0, 9'h029, 5'b11111};
    key_tbl[12] = '{1'b1, 9'h01C, 5'b11111};
    key_tbl[13] = '{1'b0, 9'h01C, 5'b11111};

    // ---- reset with every joystick bit set ----
    rst_n = 1'b0;
    joy   = 16'hFFFF;
    rot   = 1'b0;
    ps2   = 11'h000;
    repeat (3) step();
    check("reset_active_low_outs", {o_u, o_d, o_l, o_r, o_j, o_s1, o_s2, o_c1}, 8'hFF);
    check("reset_busy", o_busy, 0);
    check("reset_state", o_state, 0);
    rst_n = 1'b1;
    step();
    check("first_edge_up", o_u, 0);

    // Clear the sequence that the held start/coin bits just launched.
    joy   = 16'h0000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_after_rereset", {o_busy, o_c1, o_s1, o_s2}, 4'b0111);

    // ---- joystick / rotation table, 1 clk latency ----
    for (int i = 0; i < 11; i++) begin
      joy = dir_tbl[i].joy;
      rot = dir_tbl[i].rot;
      exp_q.push_back(dir_tbl[i].exp);
      step();
      exp = exp_q.pop_front();
      check($sformatf("dir_vec_%0d", i), dir_out, exp);
    end
    joy = 16'h0000;
    rot = 1'b0;
    repeat (2) step();

    // ---- PS/2 table, 2 clk latency ----
    prev = 5'b11111;
    for (int i = 0; i < 14; i++) begin
      send_key(key_tbl[i].pressed, key_tbl[i].code);
      exp_q.push_back(key_tbl[i].exp);
      step();
      check($sformatf("key_vec_%0d_1clk", i), dir_out, prev);
      step();
      exp = exp_q.pop_front();
      check($sformatf("key_vec_%0d_2clk", i), dir_out, exp);
      prev = exp;
    end

    // ---- hold start2: full sequence, then wait for release ----
    joy[6] = 1'b1;
    run_seq(2, 1'b0, "seq_s2");
    repeat (10) step();
    check("seq_s2 wait_busy", o_busy, 1);
    check("seq_s2 wait_state", o_state, 4);
    joy[6] = 1'b0;
    repeat (2) step();
    check("seq_s2 idle_busy", o_busy, 0);
    check("seq_s2 idle_state", o_state, 0);

    // ---- F3 coin key, start1 pressed during COIN is ignored ----
    send_key(1'b1, 9'h004);
    run_seq(0, 1'b1, "seq_coin");
    check("seq_coin wait_busy", o_busy, 1);
    check("seq_coin wait_state", o_state, 4);
    send_key(1'b0, 9'h004);
    joy[5] = 1'b0;
    repeat (4) step();
    check("seq_coin idle_busy", o_busy, 0);

    // ---- start1 and start2 together, reset during START ----
    joy[5] = 1'b1;
    joy[6] = 1'b1;
    n = 0;
    while (o_s1 !== 1'b0 && n < 60) begin step(); n++; end
    check("both_s1_selected", o_s1, 0);
    check("both_s2_stays_high", o_s2, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_s1", o_s1, 1);
    check("async_reset_busy", o_busy, 0);
    check("async_reset_state", o_state, 0);
    joy = 16'h0000;
    step();
    rst_n = 1'b1;
    repeat (2) step();

`ifdef DK_AUTOFIRE_EN
    // ---- autofire ----
    begin
      logic last_j;
      int   since;
      int   toggles;
      joy[4] = 1'b1;
      step();
      check("af_first_cycle_pressed", o_j, 0);
      last_j  = o_j;
      since   = 0;
      toggles = 0;
      for (int k = 0; k < 40; k++) begin
        step();
        since++;
        if (o_j !== last_j) begin
          check_range($sformatf("af_interval_%0d", toggles), since, 4, 12);
          toggles++;
          since  = 0;
          last_j = o_j;
        end
      end
      check_range("af_toggle_count", toggles, 3, 10);
      joy[4] = 1'b0;
      step();
      check("af_release", o_j, 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
